fifo_param: RTL
===============

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2^ADDR_W entries (2..12).
REQ-003 Parameter AFULL_TH, default 12, fifo_afull asserts when count >= AFULL_TH (1..DEPTH-1).
REQ-004 Parameter AEMPTY_TH, default 4, fifo_aempty asserts when count <= AEMPTY_TH (1..DEPTH-1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr  input  1  write request.
REQ-008 rd  input  1  read request.
REQ-009 flush  input  1  synchronous clear of contents and sticky flags.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 data_out  output  DATA_W  read data.
REQ-012 data_valid  output  1  data_out holds a valid popped/head word.
REQ-013 fifo_full, fifo_empty, fifo_afull, fifo_aempty  output  1 each  status flags.
REQ-014 fifo_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 fifo_overflow, fifo_underflow  output  1 each  sticky error flags.

Function
REQ-016 Pointers wptr/rptr SHALL be ADDR_W+1 bits; memory indexed by low ADDR_W bits; MSB toggles on wrap.
REQ-017 fifo_count SHALL equal wptr - rptr modulo 2^(ADDR_W+1); fifo_empty = (count==0); fifo_full = (count==DEPTH); all four flags combinational from registered pointers.
REQ-018 rd_acc SHALL = rd & ~fifo_empty.
REQ-019 wr_acc SHALL = wr & (~fifo_full | rd_acc): write into a full FIFO is accepted when a read is accepted the same cycle.
REQ-020 Write on empty with simultaneous rd: write accepted, read rejected (rd_acc=0).
REQ-021 On wr_acc, mem[wptr] <= data_in and wptr increments; on rd_acc, rptr increments; both in same cycle leave count unchanged.
REQ-022 fifo_overflow SHALL set on any cycle with wr & ~wr_acc; fifo_underflow SHALL set on any cycle with rd & ~rd_acc; both sticky until flush or rst.
REQ-023 flush=1 SHALL, at the clock edge, zero wptr, rptr, both sticky flags and data_valid; flush dominates wr/rd in the same cycle (no write, no read, no error set); memory contents need not be cleared.
REQ-024 Pointer wrap from 2^(ADDR_W+1)-1 to 0 SHALL be seamless; count remains correct across wrap.

Reset
REQ-025 rst=1 SHALL immediately force wptr=0, rptr=0, fifo_overflow=0, fifo_underflow=0, data_valid=0, data_out=0 (registered mode), independent of clk.
REQ-026 After reset: fifo_empty=1, fifo_aempty=1, fifo_full=0, fifo_afull=0, fifo_count=0.
REQ-027 rst asserted mid-burst SHALL discard all contents; first accepted write after release lands at address 0.

Configuration
REQ-028 Macro FIFO_FWFT_EN selects read mode.
REQ-029 FIFO_FWFT_EN undefined: data_out is a register loaded with mem[rptr] on rd_acc; data_valid = 1 for exactly the cycle after rd_acc; data_out holds last value otherwise; read latency 1 cycle.
REQ-030 FIFO_FWFT_EN defined: data_out = mem[rptr] combinationally; data_valid = ~fifo_empty; rd_acc pops the shown word; first word appears the cycle after its write.

Verification
REQ-031 Reset, write 0x01..0x10 (DEPTH=16) -> fifo_full=1, count=16, afull=1 from count 12; 17th wr -> no write, fifo_overflow=1 and stays 1.
REQ-032 From full, wr=rd=1 with data_in=0xAA -> count stays 16, overflow not set; draining returns 0x02..0x10 then 0xAA.
REQ-033 Empty FIFO, rd=1 -> fifo_underflow=1, rptr unchanged; then flush=1 -> both sticky flags 0, count 0.
REQ-034 40 write/read cycles interleaved (wrapping pointers twice) -> output sequence equals input sequence, count never exceeds 16.
REQ-035 Non-FWFT: write 0x5C, rd next cycle -> data_out=0x5C with data_valid=1 one cycle after rd; FWFT: data_out=0x5C, data_valid=1 the cycle after write, before rd.
REQ-036 rst pulsed asynchronously between clock edges with 7 words stored -> flags/count return to reset values before next edge; next write/read returns that new word.

Source files
------------

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with sticky overflow/underflow flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_afull,
    output logic              fifo_aempty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              rd_acc;
    logic              wr_acc;

    // Extra pointer MSB distinguishes full from empty; modulo subtraction survives wrap.
    assign fifo_count  = wptr - rptr;
    assign fifo_empty  = (fifo_count == '0);
    assign fifo_full   = (fifo_count == DEPTH_C);
    assign fifo_afull  = (fifo_count >= AFULL_C);
    assign fifo_aempty = (fifo_count <= AEMPTY_C);

    assign rd_acc = rd & ~fifo_empty;
    assign wr_acc = wr & (~fifo_full | rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else if (flush) begin
            wptr           <= '0;
            rptr           <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + PTR_ONE;
            if (rd_acc)
                rptr <= rptr + PTR_ONE;
            if (wr && !wr_acc)
                fifo_overflow <= 1'b1;
            if (rd && !rd_acc)
                fifo_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush)
            mem[wptr[ADDR_W-1:0]] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out   = mem[rptr[ADDR_W-1:0]];
    assign data_valid = ~fifo_empty;
`else
    // Read stage: popped word is registered and flagged for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (flush) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc)
                data_out <= mem[rptr[ADDR_W-1:0]];
        end
    end
`endif

endmodule
